uart_tx: RTL
============

Name: uart_tx

Overview:
- Asynchronous serial transmitter, 8N1 framing with a configurable stop-bit count.
- Sits between a byte-producing client (valid/ready handshake) and the serial TX pin.
- Transmits LSB first and holds each bit for CLK_FREQ/BAUD_RATE clocks.
- A one-entry holding register lets the client queue the next byte during a frame, so frames go out back-to-back with no idle gap.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 9600, serial bit rate in baud
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  synchronous reset, active-low
tx_data  input  8  byte to send; sampled on the accept edge
tx_valid  input  1  client offers tx_data
tx_ready  output  1  holding register empty; a byte is accepted when tx_valid && tx_ready at a rising edge
tx_line  output  1  serial output, registered; idles high
tx_busy  output  1  high while a frame is in progress (state != IDLE)
tx_done  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Interface: one clock (clk). Reset (reset_n) is synchronous and active-low.
- CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division); must be >= 2, checked by an elaboration-time assertion.
- clk_count width is $clog2(CLKS_PER_BIT); compare constants are sized to that width. STOP_BITS outside {1,2} is an elaboration error.
- Reset values (reset_n low at an edge): state=IDLE, tx_line=1, tx_busy=0, tx_done=0, holding register empty (tx_ready=1), clk_count=0, bit_index=0, shift register=0.
- Reset mid-frame: tx_line returns high at that edge, any queued byte is discarded, and no tx_done is produced.
- Holding register:
  - tx_ready = !hold_valid, taken combinationally from the register.
  - Accept at edge k sets hold_valid and captures tx_data.
  - Accept and unload on the same edge cannot occur: unload needs hold_valid=1, which forces tx_ready=0.
- tx_done defaults to 0 every cycle; it is high only in the cycle after the final stop-bit edge.
- IDLE:
  - tx_line=1.
  - If hold_valid: load the shift register from the holding register, clear hold_valid, clk_count=0, go to START.
  - Latency: byte accepted at edge k -> START at edge k+1 -> tx_line low from edge k+1.
- START:
  - tx_line=0 for exactly CLKS_PER_BIT cycles.
  - When clk_count==CLKS_PER_BIT-1: clk_count=0, bit_index=0, go to DATA.
- DATA:
  - tx_line = shift[bit_index]; each bit is held CLKS_PER_BIT cycles.
  - At count end: bit_index increments; after bit_index==7 completes, go to STOP with stop_count=0.
- STOP:
  - tx_line=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the end of the final stop bit: pulse tx_done.
  - If hold_valid: reload the shift register, clear hold_valid, go directly to START (zero idle cycles between frames).
  - Otherwise: go to IDLE.
- tx_busy is registered and equals (next state != IDLE), so it is high from the edge that enters START through the edge returning to IDLE.
- tx_line is glitch-free: it is driven only from state flops and the shift register.
- tx_data/tx_valid changing while tx_ready=0 have no effect.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP), 2 bits, same encoding as the receiver;
  - DATA_BITS=8;
  - a function clks_per_bit(clk_freq, baud) used by both TX and RX.
- Natural sub-module: uart_baud_tick, a counter that emits a 1-cycle tick every CLKS_PER_BIT clocks and restarts on a sync clear.
- The FSM and holding register stay in uart_tx.

Test Plan:
1. CLK_FREQ=80, BAUD_RATE=10 (8 clks/bit), send 0xA5 -> after start bit, tx_line reads 1,0,1,0,0,1,0,1; each level lasts exactly 8 cycles; one tx_done pulse 80 cycles after the start-bit fall; tx_busy high for exactly 80 cycles.
2. Back-to-back: offer 0x00, then 0xFF while the first is in DATA -> tx_ready drops after the second accept; the stop bit of frame 1 is followed immediately by the start bit of frame 2 (0 idle cycles); two tx_done pulses 80 cycles apart.
3. Backpressure: hold tx_valid high with changing tx_data while the holding register is full -> no accept, tx_ready=0, transmitted bytes are the two originally accepted values only.
4. Reset mid-frame: assert reset_n=0 for one cycle at bit 3 of 0x3C with a queued byte -> tx_line=1, tx_busy=0, tx_ready=1 at the next edge; no tx_done; the queued byte is never sent.
5. STOP_BITS=2, 8 clks/bit, send 0x81 -> stop level lasts 16 cycles; tx_done comes 88 cycles after the start fall.
6. Idle check: after reset, no tx_valid for 1000 cycles -> tx_line stays 1, tx_busy=0, tx_done never pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, data width and bit-timing helper shared by the UART transmitter and receiver.
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} uart_state_e;
  localparam int DATA_BITS = 8;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running bit-period counter; tick marks the last clock of each bit, clr holds it at zero.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] clk_count_q, clk_count_d;
  always_comb begin
    tick = clk_count_q == LAST;
    clk_count_d = (clr || tick) ? '0 : clk_count_q + 1'b1;
  end
  always_ff @(posedge clk)
    clk_count_q <= !reset_n ? '0 : clk_count_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter (1 or 2 stop bits) with a one-entry holding register
// so a queued byte starts right after the previous frame's last stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_line,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  if (CLKS_PER_BIT < 2) begin : g_bad_rate
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  uart_state_e state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, hold_data_q, hold_data_d;
  logic [BW-1:0] bit_index_q, bit_index_d;
  logic hold_valid_q, hold_valid_d, stop_count_q, stop_count_d;
  logic tx_line_q, tx_line_d, tx_busy_q, tx_busy_d, tx_done_q, tx_done_d;
  logic tick, accept, last_stop;
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_q == IDLE),
    .tick    (tick)
  );
  always_comb begin
    accept = tx_valid && !hold_valid_q;
    last_stop = state_q == STOP && tick && stop_count_q == STOP_LAST;
    state_d = state_q;
    shift_d = shift_q;
    bit_index_d = bit_index_q;
    stop_count_d = stop_count_q;
    hold_valid_d = hold_valid_q || accept;
    hold_data_d = accept ? tx_data : hold_data_q;
    tx_done_d = last_stop;
    case (state_q)
      IDLE: if (hold_valid_q) begin
        shift_d = hold_data_q;
        hold_valid_d = 1'b0;
        state_d = START;
      end
      START: if (tick) begin
        bit_index_d = '0;
        state_d = DATA;
      end
      DATA: if (tick) begin
        bit_index_d = bit_index_q + 1'b1;
        if (bit_index_q == BIT_LAST) begin
          stop_count_d = 1'b0;
          state_d = STOP;
        end
      end
      STOP: if (tick) begin
        stop_count_d = stop_count_q + 1'b1;
        if (last_stop) begin
          state_d = hold_valid_q ? START : IDLE;
          shift_d = hold_valid_q ? hold_data_q : shift_q;
          hold_valid_d = 1'b0;
        end
      end
    endcase
    // outputs come from next-state values so tx_line changes on the same edge as the state
    tx_line_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[bit_index_d] : 1'b1;
    tx_busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      hold_data_q <= '0;
      hold_valid_q <= 1'b0;
      bit_index_q <= '0;
      stop_count_q <= 1'b0;
      tx_line_q <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      hold_data_q <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      bit_index_q <= bit_index_d;
      stop_count_q <= stop_count_d;
      tx_line_q <= tx_line_d;
      tx_busy_q <= tx_busy_d;
      tx_done_q <= tx_done_d;
    end
  assign tx_ready = !hold_valid_q;
  assign tx_line = tx_line_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;
endmodule
